// File: rtl/commutation_scheduler_if.sv
// LUT handshake bundle between the commutation scheduler and the shared
// sine/duty lookup table.
//   master (scheduler): drives lut_req/lut_addr, receives lut_ack/lut_data
//   slave  (LUT)      : the mirror image
// lut_data is valid in the same cycle lut_ack is high.
interface commutation_scheduler_if #(
  parameter int DUTY_W = 10
);
  logic              lut_req;
  logic [10:0]       lut_addr;
  logic              lut_ack;
  logic [DUTY_W-1:0] lut_data;

  modport master (output lut_req, lut_addr, input lut_ack, lut_data);
  modport slave  (input lut_req, lut_addr, output lut_ack, lut_data);
endinterface

// File: rtl/commutation_scheduler.sv
// Commutation scheduler: on every sample tick, captures encoder_count +
// lead_counts, reduces it modulo one electrical period by repeated
// subtraction, then looks up the duty for phases A/B/C (offset 0, 1/3, 2/3
// period) through one shared LUT and publishes all three at once.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   enable              runs the sample divider; low also clears overrun
//   encoder_count[13]   raw encoder position
//   lead_counts[11]     phase advance in counts
//   lut                 LUT request/ack bus (master side)
//   duty_a/b/c          registered phase duties
//   duty_valid          one-cycle pulse when the duties update
//   busy                FSM not idle
//   overrun             sticky: a tick was dropped because we were busy
module commutation_scheduler #(
  parameter int COUNTS_PER_ELEC = 1170,
  parameter int PHASE_OFFSET    = 390,
  parameter int SAMPLE_DIV      = 1000,
  parameter int DUTY_W          = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [12:0]              encoder_count,
  input  logic [10:0]              lead_counts,
  commutation_scheduler_if.master  lut,
  output logic [DUTY_W-1:0]        duty_a,
  output logic [DUTY_W-1:0]        duty_b,
  output logic [DUTY_W-1:0]        duty_c,
  output logic                     duty_valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [13:0]   CPE14    = 14'(COUNTS_PER_ELEC);
  localparam logic [11:0]   CPE12    = 12'(COUNTS_PER_ELEC);

  typedef enum logic [2:0] {IDLE, CAPTURE, REDUCE, ISSUE, WAIT, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [13:0]       acc_q, acc_d;
  logic [10:0]       angle_q, angle_d;
  logic [1:0]        phase_q, phase_d;
  logic              req_q, req_d;
  logic [10:0]       addr_q, addr_d;
  logic [DUTY_W-1:0] sha_q, sha_d, shb_q, shb_d;
  logic [DUTY_W-1:0] da_q, da_d, db_q, db_d, dc_q, dc_d;
  logic              dv_q, dv_d;
  logic              ovr_q, ovr_d;
  logic              tick;
  logic [11:0]       addr_raw;

  assign tick     = enable && (cnt_q == CNT_LAST);
  // angle < period and phase*offset <= 2/3 period, so one conditional
  // subtraction is enough to bring the address back into range
  assign addr_raw = {1'b0, angle_q} + 12'(int'(phase_q) * PHASE_OFFSET);

  always_comb begin
    state_d = state_q;
    cnt_d   = enable ? ((cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1) : '0;
    acc_d   = acc_q;
    angle_d = angle_q;
    phase_d = phase_q;
    req_d   = req_q;
    addr_d  = addr_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    da_d    = da_q;
    db_d    = db_q;
    dc_d    = dc_q;
    dv_d    = 1'b0;
    // a tick in any non-idle state (UPDATE included) is dropped and flagged
    ovr_d   = enable ? (ovr_q | (tick && state_q != IDLE)) : 1'b0;

    case (state_q)
      IDLE:    if (tick) state_d = CAPTURE;
      CAPTURE: begin
        acc_d   = {1'b0, encoder_count} + 14'(lead_counts);
        state_d = REDUCE;
      end
      REDUCE: begin
        if (acc_q >= CPE14) begin
          acc_d = acc_q - CPE14;
        end else begin
          angle_d = acc_q[10:0];
          phase_d = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        addr_d  = (addr_raw >= CPE12) ? 11'(addr_raw - CPE12) : addr_raw[10:0];
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (lut.lut_ack) begin
          req_d = 1'b0;
          if (phase_q < 2'd2) begin
            if (phase_q == 2'd0) sha_d = lut.lut_data;
            else                 shb_d = lut.lut_data;
            phase_d = phase_q + 2'd1;
            state_d = ISSUE;
          end else begin
            // phase C data goes straight to its output so the duties and
            // duty_valid become visible together in the UPDATE cycle
            da_d    = sha_q;
            db_d    = shb_q;
            dc_d    = lut.lut_data;
            dv_d    = 1'b1;
            state_d = UPDATE;
          end
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      angle_q <= '0;
      phase_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      da_q    <= '0;
      db_q    <= '0;
      dc_q    <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      angle_q <= angle_d;
      phase_q <= phase_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      da_q    <= da_d;
      db_q    <= db_d;
      dc_q    <= dc_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign lut.lut_req  = req_q;
  assign lut.lut_addr = addr_q;
  assign duty_a       = da_q;
  assign duty_b       = db_q;
  assign duty_c       = dc_q;
  assign duty_valid   = dv_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_commutation_scheduler.sv
module tb_commutation_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [12:0] encoder_count = '0;
  logic [10:0] lead_counts = '0;
  logic [9:0]  duty_a, duty_b, duty_c;
  logic        duty_valid, busy, overrun;

  commutation_scheduler_if #(.DUTY_W(10)) lut_if ();

  commutation_scheduler #(
    .COUNTS_PER_ELEC(1170), .PHASE_OFFSET(390), .SAMPLE_DIV(32), .DUTY_W(10)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .encoder_count(encoder_count), .lead_counts(lead_counts),
    .lut(lut_if),
    .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
    .duty_valid(duty_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // LUT model: acks after ack_dly cycles of request, data = addr[9:0]
  int ack_dly = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    if (lut_if.lut_req && !lut_if.lut_ack) wait_cnt <= wait_cnt + 1;
    else                                   wait_cnt <= 0;
  end
  assign lut_if.lut_ack  = lut_if.lut_req && (wait_cnt >= ack_dly);
  assign lut_if.lut_data = lut_if.lut_addr[9:0];

  typedef struct { int a; int b; int c; } duty_t;
  int    addr_q[$];
  duty_t duty_q[$];

  int n_total = 0, n_bad = 0;
  int cyc = 0, busy_rise = 0, last_dv = 0, dv_cnt = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one cycle, sample at the falling edge, run the scoreboard
  task automatic step();
    duty_t e;
    int    a;
    @(negedge clk);
    cyc++;
    if (busy && !busy_prev) busy_rise = cyc;
    busy_prev = busy;
    if (lut_if.lut_req) chk("addr_range", (lut_if.lut_addr < 11'd1170) ? 1 : 0, 1);
    if (lut_if.lut_req && lut_if.lut_ack) begin
      if (addr_q.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        a = addr_q.pop_front();
        chk("lut_addr", int'(lut_if.lut_addr), a);
      end
    end
    if (duty_valid) begin
      dv_cnt++;
      last_dv = cyc;
      if (duty_q.size() == 0) chk("unexpected_duty_valid", 1, 0);
      else begin
        e = duty_q.pop_front();
        chk("duty_a", int'(duty_a), e.a);
        chk("duty_b", int'(duty_b), e.b);
        chk("duty_c", int'(duty_c), e.c);
      end
    end
  endtask

  task automatic expect_seq(input int a0, input int a1, input int a2);
    duty_t d;
    addr_q.push_back(a0);
    addr_q.push_back(a1);
    addr_q.push_back(a2);
    d.a = a0 % 1024; d.b = a1 % 1024; d.c = a2 % 1024;
    duty_q.push_back(d);
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int start;
    start = dv_cnt;
    for (int i = 0; i < budget && dv_cnt == start; i++) step();
    if (dv_cnt == start) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_seq(input int enc, input int lead, input int dly,
                         input int a0, input int a1, input int a2);
    encoder_count = 13'(enc);
    lead_counts   = 11'(lead);
    ack_dly       = dly;
    expect_seq(a0, a1, a2);
    wait_dv("seq", 200);
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_req", int'(lut_if.lut_req), 0);
    chk("rst_addr", int'(lut_if.lut_addr), 0);
    chk("rst_duty_a", int'(duty_a), 0);
    chk("rst_duty_c", int'(duty_c), 0);
    chk("rst_dv", int'(duty_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);

    // basic sequence, ack one cycle after each request
    reset  = 1'b1;
    enable = 1'b1;
    run_seq(0, 0, 1, 0, 390, 780);
    chk("dv_count1", dv_cnt, 1);
    step();
    chk("dv_one_cycle", int'(duty_valid), 0);

    // 7 subtractions, zero-wait ack: duty_valid 16 cycles after tick,
    // i.e. 15 cycles after busy rises in CAPTURE
    run_seq(8191, 0, 0, 1, 391, 781);
    chk("latency", last_dv - busy_rise, 15);

    // exact period boundary, then wrap of phase addresses
    run_seq(1169, 1, 0, 0, 390, 780);
    run_seq(1000, 0, 0, 1000, 220, 610);
    // largest accumulator
    run_seq(8191, 2047, 1, 878, 98, 488);
    chk("no_overrun_yet", int'(overrun), 0);

    // slow LUT: ticks land while busy
    begin
      int dv0;
      dv0 = dv_cnt;
      run_seq(500, 0, 20, 500, 890, 110);
      chk("overrun_set", int'(overrun), 1);
      chk("one_dv_slow", dv_cnt - dv0, 1);
      enable = 1'b0;
      step();
      chk("overrun_cleared", int'(overrun), 0);
      repeat (40) step();
      chk("no_dv_disabled", dv_cnt - dv0, 1);
    end

    // reset pulse during the second WAIT
    begin
      int dv0;
      bit hit;
      hit = 0;
      ack_dly = 1;
      encoder_count = 13'd0;
      lead_counts = 11'd0;
      enable = 1'b1;
      expect_seq(0, 390, 780);
      for (int i = 0; i < 200 && !hit; i++) begin
        step();
        if (lut_if.lut_req && !lut_if.lut_ack && addr_q.size() == 2) hit = 1;
      end
      chk("reached_second_wait", int'(hit), 1);
      dv0 = dv_cnt;
      reset = 1'b0;
      step();
      chk("rst_mid_req", int'(lut_if.lut_req), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_duty_a", int'(duty_a), 0);
      chk("rst_mid_duty_b", int'(duty_b), 0);
      addr_q.delete();
      duty_q.delete();
      reset = 1'b1;
      repeat (5) step();
      chk("rst_mid_no_dv", dv_cnt - dv0, 0);
      // restart from phase A
      run_seq(1000, 0, 0, 1000, 220, 610);
    end

    enable = 1'b0;
    repeat (3) step();
    chk("addr_q_empty", addr_q.size(), 0);
    chk("duty_q_empty", duty_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/commutation_scheduler.md
Name: commutation_scheduler

Overview:
- Periodically samples the 13-bit rotor encoder count, adds a phase-lead term, and reduces the sum modulo one electrical period with an iterative subtractor.
- Time-shares a single external sine/duty lookup table among phases A, B and C (offsets 0, 1/3 and 2/3 of a period), then publishes all three duties together.
- Sits between the encoder interface and the PWM generators in the BLDC velocity controller.

Parameters:
- COUNTS_PER_ELEC, 1170, encoder counts per electrical revolution.
- PHASE_OFFSET, 390, counts between successive phases (COUNTS_PER_ELEC/3).
- SAMPLE_DIV, 1000, clock cycles between sample ticks (≥ 32).
- DUTY_W, 10, width of LUT data and duty outputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; asserted when low, sampled on rising clk.
- enable  in  1  run the sample divider and scheduler.
- encoder_count  in  13  raw encoder position.
- lead_counts  in  11  phase advance in counts, any value 0..2047.
- lut_req  out  1  LUT request; held until acknowledged.
- lut_addr  out  11  LUT address, always < COUNTS_PER_ELEC while lut_req is high.
- lut_ack  in  1  LUT acknowledge; lut_data is valid in the same cycle.
- lut_data  in  DUTY_W  LUT output.
- duty_a, duty_b, duty_c  out  DUTY_W  registered phase duties.
- duty_valid  out  1  one-cycle pulse when the three duties update.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (reset==0): all outputs 0, FSM to IDLE, tick counter 0, phase index 0, overrun 0.
- Tick counter: counts 0..SAMPLE_DIV-1 while enable=1 and wraps. The tick is the cycle in which the counter equals SAMPLE_DIV-1. With enable=0 the counter is held at 0.
- enable=0 also clears overrun. Duty outputs hold their last values.
- FSM states: IDLE, CAPTURE, REDUCE, ISSUE, WAIT, UPDATE.
  - IDLE: on a tick, go to CAPTURE.
  - CAPTURE: acc (14 bits) = encoder_count + lead_counts, zero-extended. Go to REDUCE.
  - REDUCE: each cycle, if acc ≥ COUNTS_PER_ELEC then acc -= COUNTS_PER_ELEC; otherwise latch angle = acc, set phase=0 and go to ISSUE. This takes floor(acc/1170)+1 cycles, at most 9.
  - ISSUE: compute addr = angle + phase*PHASE_OFFSET, then subtract COUNTS_PER_ELEC once if addr ≥ COUNTS_PER_ELEC. Register addr to lut_addr, raise lut_req, go to WAIT.
  - WAIT: hold lut_req and lut_addr stable until lut_ack.
    - On lut_ack: store lut_data in the shadow register for that phase and drop lut_req next cycle.
    - If phase<2: phase++, go to ISSUE. Otherwise go to UPDATE.
    - No timeout.
  - UPDATE: copy the shadow registers to duty_a/b/c together, pulse duty_valid for 1 cycle, go to IDLE.
- lut_ack outside WAIT is ignored.
- Latency with zero-wait ack (ack in the first WAIT cycle): tick at cycle T, duty_valid at T+1+(k+1)+6+1, where k = subtractions.
- Tick while busy: sample dropped, overrun set, current sequence continues unaffected.
- Tick in the same cycle as UPDATE: counts as busy, so overrun is set. The next sample is taken at the following tick.
- enable falling mid-sequence: current sequence completes, no new ticks.
- reset low mid-sequence: immediate return to reset values; lut_req drops the next edge.

Test Plan:
- Reset, enable=1, encoder=0, lead=0, ack returned the cycle after each req -> lut_addr sequence 0, 390, 780. With LUT returning addr[9:0]: duty_a=0, duty_b=390, duty_c=780, one duty_valid pulse.
- encoder=8191, lead=0 -> 7 subtractions, angle 1; addrs 1, 391, 781; duty_valid 16 cycles after tick with zero-wait ack.
- encoder=1169, lead=1 -> angle 0 (exact boundary); addrs 0, 390, 780. Then encoder=1000, lead=0 -> addrs 1000, 220, 610 (wrap).
- encoder=8191, lead=2047 -> acc 10238, 8 subtractions, angle 878; addrs 878, 98, 488.
- SAMPLE_DIV=32, ack delayed 20 cycles -> tick during WAIT sets overrun, no extra duty_valid. Driving enable=0 clears overrun.
- Pull reset low for 1 cycle during the second WAIT -> lut_req=0, busy=0, duties retain reset value 0, no duty_valid. Next tick restarts at phase A.
